// File: rtl/dot_matrix_scroller_pkg.sv
// Shared definitions for the dot-matrix scroller: display modes, blank code, 7-segment table.
package dms_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_STATIC = 2'd0;
    localparam mode_t MODE_LEFT   = 2'd1;
    localparam mode_t MODE_RIGHT  = 2'd2;
    localparam mode_t MODE_BLINK  = 2'd3;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // {g,f,e,d,c,b,a}; non-decimal codes render dark
    function automatic logic [6:0] seg_of(input logic [3:0] code);
        logic [6:0] s;
        s = 7'h00;
        case (code)
            4'd0: s = 7'h3F;
            4'd1: s = 7'h06;
            4'd2: s = 7'h5B;
            4'd3: s = 7'h4F;
            4'd4: s = 7'h66;
            4'd5: s = 7'h6D;
            4'd6: s = 7'h7D;
            4'd7: s = 7'h07;
            4'd8: s = 7'h7F;
            4'd9: s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dot_matrix_scroller_if.sv
// Control-side bus of the scroller: message/mode in, matrix and 7-segment drive out.
interface dot_matrix_scroller_if
    import dms_pkg::*;
#(
    parameter int unsigned ROWS    = 16,
    parameter int unsigned COLS    = 16,
    parameter int unsigned NDIGITS = 4
);
    localparam int unsigned RW = $clog2(ROWS);

    logic [4*NDIGITS-1:0] digits_in;
    logic                 load;
    mode_t                mode;
    logic [COLS-1:0]      col_n;
    logic [RW-1:0]        row_bin;
    logic                 frame_tick;
    logic [7:0]           seg7_0;

    modport master (
        output digits_in, load, mode,
        input  col_n, row_bin, frame_tick, seg7_0
    );

    modport slave (
        input  digits_in, load, mode,
        output col_n, row_bin, frame_tick, seg7_0
    );
endinterface

// File: rtl/dot_matrix_scroller_font_rom.sv
// Glyph generator: draws a digit as a segment-style figure, one row at a time.
module digit_font_rom
    import dms_pkg::*;
#(
    parameter int unsigned ROWS    = 16,
    parameter int unsigned GLYPH_W = 8,
    localparam int unsigned RW     = $clog2(ROWS)
) (
    input  logic [3:0]         code_i,
    input  logic [RW-1:0]      row_i,
    output logic [GLYPH_W-1:0] bits_o
);

    // Column 1 is the left stroke, column GLYPH_W-3 the right stroke; the rest is spacing
    localparam logic [GLYPH_W-1:0] HORIZ = GLYPH_W'((1 << (GLYPH_W - 1)) - 4);
    localparam logic [GLYPH_W-1:0] LEFT  = GLYPH_W'(1 << (GLYPH_W - 2));
    localparam logic [GLYPH_W-1:0] RIGHT = GLYPH_W'(4);

    logic [6:0]  seg_c;
    logic [31:0] band_c;

    // Rows are folded onto a 16-band layout: a | f,b | g | e,c | d
    always_comb begin
        seg_c  = seg_of(code_i);
        band_c = (32'(row_i) * 32'd16) / ROWS;
        bits_o = '0;
        if (band_c < 32'd2) begin
            if (seg_c[0]) bits_o = HORIZ;
        end else if (band_c < 32'd7) begin
            bits_o = (seg_c[5] ? LEFT : '0) | (seg_c[1] ? RIGHT : '0);
        end else if (band_c < 32'd9) begin
            if (seg_c[6]) bits_o = HORIZ;
        end else if (band_c < 32'd14) begin
            bits_o = (seg_c[4] ? LEFT : '0) | (seg_c[2] ? RIGHT : '0);
        end else begin
            if (seg_c[3]) bits_o = HORIZ;
        end
    end

endmodule

// File: rtl/dot_matrix_scroller.sv
// Row-scanned LED matrix driver with a loadable digit message and scroll/blink animation;
// also mirrors the leftmost visible digit on a 7-segment display.
module dot_matrix_scroller
    import dms_pkg::*;
#(
    parameter int unsigned ROWS        = 16,
    parameter int unsigned COLS        = 16,
    parameter int unsigned GLYPH_W     = 8,
    parameter int unsigned NDIGITS     = 4,
    parameter int unsigned SCAN_DIV    = 16,
    parameter int unsigned ANIM_FRAMES = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    dot_matrix_scroller_if.slave         bus
);

    localparam int unsigned RW    = $clog2(ROWS);
    localparam int unsigned W     = NDIGITS * GLYPH_W;
    localparam int unsigned OW    = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned FW    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int unsigned SLOTS = (COLS + GLYPH_W - 1) / GLYPH_W + 1;
    localparam int unsigned WINW  = SLOTS * GLYPH_W;

    logic [SCAN_DIV-1:0]  presc_q, presc_d;
    logic [RW-1:0]        row_q, row_d;
    logic [COLS-1:0]      col_n_q, col_n_d;
    logic                 frame_tick_q, frame_tick_d;
    logic                 upd_q, upd_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic [OW-1:0]        offset_q, offset_d;
    logic                 blink_q, blink_d;
    logic [4*NDIGITS-1:0] buf_q, buf_d;
    mode_t                mode_q, mode_d;
    logic [7:0]           seg7_q, seg7_d;

    logic                 scan_tick_c;
    logic                 frame_wrap_c;
    logic                 dark_c;
    logic [31:0]          base_c;
    logic [31:0]          sub_c;
    logic [4*SLOTS-1:0]   slot_code_c;
    logic [WINW-1:0]      window_c;
    logic [COLS-1:0]      pattern_c;

    // Glyph slots covering the visible window, starting at the digit under the left edge
    always_comb begin
        base_c      = 32'(offset_q) / GLYPH_W;
        sub_c       = 32'(offset_q) % GLYPH_W;
        slot_code_c = '0;
        for (int j = 0; j < int'(SLOTS); j++) begin
            slot_code_c[4*j +: 4] = buf_q[4*((base_c + 32'(j)) % NDIGITS) +: 4];
        end
    end

    for (genvar j = 0; j < int'(SLOTS); j++) begin : g_slot
        digit_font_rom #(
            .ROWS    (ROWS),
            .GLYPH_W (GLYPH_W)
        ) u_rom (
            .code_i (slot_code_c[4*j +: 4]),
            .row_i  (row_q),
            .bits_o (window_c[WINW-1-j*GLYPH_W -: GLYPH_W])
        );
    end

    // Leftmost window bit lands on col_n[COLS-1]; sub-glyph offset shifts the window left
    always_comb begin
        pattern_c = COLS'(window_c >> (32'(WINW - COLS) - sub_c));
    end

    always_comb begin
        presc_d      = presc_q + SCAN_DIV'(1);
        row_d        = row_q;
        col_n_d      = col_n_q;
        frame_tick_d = 1'b0;
        upd_d        = 1'b0;
        fcnt_d       = fcnt_q;
        offset_d     = offset_q;
        blink_d      = blink_q;
        buf_d        = buf_q;
        mode_d       = bus.mode;
        seg7_d       = seg7_q;

        scan_tick_c  = (presc_q == '1);
        frame_wrap_c = frame_tick_q && (fcnt_q == FW'(ANIM_FRAMES - 1));
        dark_c       = (bus.mode == MODE_BLINK) && !blink_q;

        // Blank the columns while the row select moves, then paint the new row
        if (scan_tick_c) begin
            row_d        = row_q + RW'(1);
            col_n_d      = '1;
            frame_tick_d = (row_q == RW'(ROWS - 1));
            upd_d        = 1'b1;
        end else if (upd_q) begin
            col_n_d = dark_c ? '1 : ~pattern_c;
        end

        if (frame_tick_q) begin
            fcnt_d = frame_wrap_c ? '0 : fcnt_q + FW'(1);
        end

        if (frame_wrap_c) begin
            case (bus.mode)
                MODE_LEFT:  offset_d = (offset_q == OW'(W - 1)) ? '0 : offset_q + OW'(1);
                MODE_RIGHT: offset_d = (offset_q == '0) ? OW'(W - 1) : offset_q - OW'(1);
                MODE_BLINK: blink_d  = ~blink_q;
                default:    offset_d = offset_q;
            endcase
        end

        if ((bus.mode == MODE_BLINK) && (mode_q != MODE_BLINK)) blink_d = 1'b1;
        if (bus.mode == MODE_STATIC) offset_d = '0;

        // A new message restarts the animation from the first frame
        if (bus.load) begin
            buf_d    = bus.digits_in;
            offset_d = '0;
            fcnt_d   = '0;
            blink_d  = 1'b1;
        end

        seg7_d = {(bus.mode == MODE_LEFT) || (bus.mode == MODE_RIGHT),
                  seg_of(buf_q[4*base_c +: 4])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            row_q        <= '0;
            col_n_q      <= '1;
            frame_tick_q <= 1'b0;
            upd_q        <= 1'b0;
            fcnt_q       <= '0;
            offset_q     <= '0;
            blink_q      <= 1'b1;
            buf_q        <= {NDIGITS{BLANK_CODE}};
            mode_q       <= MODE_STATIC;
            seg7_q       <= '0;
        end else begin
            presc_q      <= presc_d;
            row_q        <= row_d;
            col_n_q      <= col_n_d;
            frame_tick_q <= frame_tick_d;
            upd_q        <= upd_d;
            fcnt_q       <= fcnt_d;
            offset_q     <= offset_d;
            blink_q      <= blink_d;
            buf_q        <= buf_d;
            mode_q       <= mode_d;
            seg7_q       <= seg7_d;
        end
    end

    assign bus.col_n      = col_n_q;
    assign bus.row_bin    = row_q;
    assign bus.frame_tick = frame_tick_q;
    assign bus.seg7_0     = seg7_q;

endmodule
